pipe_wb_regfile: RTL and testbench

- Write-back end of the execute-stage result interface: captures the execute stage's result (wd), destination (wa_e) and ALU flags in an EXE/WB pipeline register.
- Commits the result into the 32x32 general-purpose register file.
- Serves the decode stage's two read ports (which feed rd1/rd2 of execute), with full forwarding from the EXE and WB stages.

---
 rtl/pipe_wb_regfile.sv | 111 +++++++++++
 tb/tb_pipe_wb_regfile.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wb_regfile.sv
// Purpose : EXE/WB pipeline register, 32xDW register file commit, and two
//           forwarded decode read ports.
// Latency : result at execute in cycle N is readable in N (EXE forward),
//           N+1 (WB bypass) and N+2 onward (array); no flow control, the WB
//           stage always commits, and stall freezes only the EXE/WB register.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   stall, flush      hazard-unit control of the EXE/WB register (flush wins)
//   wen_e, wa_e, wd   execute-stage write enable, destination and result
//   carry, negative,
//   overflow          execute-stage ALU flags
//   ra1/rd1, ra2/rd2  decode read ports (combinational data)
//   wb_valid, wb_wa,
//   wb_wd             WB-stage register write in flight
//   flags             {overflow, negative, carry} of last committed writer
module pipe_wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          wen_e,
    input  logic [AW-1:0] wa_e,
    input  logic [DW-1:0] wd,
    input  logic          carry,
    input  logic          negative,
    input  logic          overflow,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          wb_valid,
    output logic [AW-1:0] wb_wa,
    output logic [DW-1:0] wb_wd,
    output logic [2:0]    flags
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0] regs [NREGS];

    // A write to r0 never becomes live, so r0 is never touched after reset.
    logic exe_live;
    assign exe_live = wen_e & (|wa_e);

    // ------------------------------------------------------------------
    // EXE/WB pipeline register: flush > stall > load
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_wa    <= '0;
            wb_wd    <= '0;
            flags    <= 3'b000;
        end else if (flush) begin
            // Flags belong to the last committed writer, so a bubble keeps them.
            wb_valid <= 1'b0;
            wb_wa    <= '0;
            wb_wd    <= '0;
        end else if (!stall) begin
            wb_valid <= exe_live;
            wb_wa    <= wa_e;
            wb_wd    <= wd;
            if (wen_e) begin
                flags <= {overflow, negative, carry};
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file commit. Uses the WB contents present before this edge,
    // so an entry being flushed on the same edge still lands in the array.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid && (|wb_wa)) begin
            regs[wb_wa] <= wb_wd;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: r0, then the younger EXE result, then the WB entry,
    // then the array. The EXE path uses wen_e directly; wa_e==0 is already
    // caught by the r0 check since ra must equal wa_e to hit.
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra);
        logic [DW-1:0] data;
        if (ra == '0) begin
            data = '0;
        end else if (wen_e && (wa_e == ra)) begin
            data = wd;
        end else if (wb_valid && (wb_wa == ra)) begin
            data = wb_wd;
        end else begin
            data = regs[ra];
        end
        return data;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: tb/tb_pipe_wb_regfile.sv
module tb_pipe_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, flush, wen_e;
    logic [4:0]  wa_e, ra1, ra2;
    logic [31:0] wd;
    logic        carry, negative, overflow;
    logic [31:0] rd1, rd2;
    logic        wb_valid;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers plus the one write in flight.
    logic [31:0] m_regs [32];
    logic        m_wb_valid;
    logic [4:0]  m_wb_wa;
    logic [31:0] m_wb_wd;
    logic [2:0]  m_flags;

    pipe_wb_regfile #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .wen_e(wen_e), .wa_e(wa_e), .wd(wd),
        .carry(carry), .negative(negative), .overflow(overflow),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_valid(wb_valid), .wb_wa(wb_wa), .wb_wd(wb_wd), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_wb_valid = 1'b0;
        m_wb_wa    = '0;
        m_wb_wd    = '0;
        m_flags    = 3'b000;
    endtask

    // Newest producer of a register wins; r0 is always zero.
    function automatic logic [31:0] model_read(input logic [4:0] ra);
        if (ra == 0) return 32'h0;
        if (wen_e && wa_e == ra) return wd;
        if (m_wb_valid && m_wb_wa == ra) return m_wb_wd;
        return m_regs[ra];
    endfunction

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (m_wb_valid) m_regs[m_wb_wa] = m_wb_wd;
            if (flush) begin
                m_wb_valid = 1'b0;
                m_wb_wa    = '0;
                m_wb_wd    = '0;
            end else if (!stall) begin
                m_wb_valid = wen_e && (wa_e != 0);
                m_wb_wa    = wa_e;
                m_wb_wd    = wd;
                if (wen_e) m_flags = {overflow, negative, carry};
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; wen_e = 0; wa_e = 0; wd = 0;
        carry = 0; negative = 0; overflow = 0;
    endtask

    task automatic drive_wr(input logic [4:0] a, input logic [31:0] d);
        wen_e = 1; wa_e = a; wd = d;
    endtask

    task automatic test_reset();
        idle(); ra1 = 5; ra2 = 0;
        model_reset();
        tick();
        if (rd1 !== 32'h0 || wb_valid !== 1'b0 || flags !== 3'b000) begin
            errors++;
            $display("FAIL reset_init: rd1=%h wb_valid=%b flags=%b required 0/0/000", rd1, wb_valid, flags);
        end
        checks++;
        rst = 0;
        drive_wr(5, 32'h1234); tick();
        wen_e = 0; tick();
        #1;
        if (rd1 !== 32'h1234) begin
            errors++;
            $display("FAIL reset_prewrite: rd1=%h required 00001234", rd1);
        end
        checks++;
        drive_wr(6, 32'h5555); overflow = 1; negative = 1; carry = 1; tick();
        idle();
        // Mid-cycle asynchronous reset
        #2 rst = 1;
        model_reset();
        #1;
        if (rd1 !== 32'h0 || wb_valid !== 1'b0 || flags !== 3'b000 || wb_wd !== 32'h0 || wb_wa !== 5'd0) begin
            errors++;
            $display("FAIL reset_async: rd1=%h wb_valid=%b wb_wa=%0d wb_wd=%h flags=%b required all zero",
                     rd1, wb_valid, wb_wa, wb_wd, flags);
        end
        checks++;
        #1 rst = 0;
        drive_wr(8, 32'hCAFE0001); tick();
        if (wb_valid !== 1'b1 || wb_wa !== 5'd8 || wb_wd !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL reset_first_capture: wb_valid=%b wb_wa=%0d wb_wd=%h required 1/8/cafe0001",
                     wb_valid, wb_wa, wb_wd);
        end
        checks++;
        idle(); tick();
    endtask

    task automatic test_write_path();
        idle(); ra1 = 3; ra2 = 4;
        drive_wr(3, 32'hDEADBEEF);
        #1;
        if (rd1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wp_exe: rd1=%h required deadbeef", rd1);
        end
        checks++;
        tick();
        wen_e = 0; #1;
        if (rd1 !== 32'hDEADBEEF || wb_valid !== 1'b1 || wb_wa !== 5'd3) begin
            errors++;
            $display("FAIL wp_wb: rd1=%h wb_valid=%b wb_wa=%0d required deadbeef/1/3", rd1, wb_valid, wb_wa);
        end
        checks++;
        tick();
        if (rd1 !== 32'hDEADBEEF || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL wp_array: rd1=%h wb_valid=%b required deadbeef/0", rd1, wb_valid);
        end
        checks++;
    endtask

    task automatic test_r0();
        idle(); ra1 = 0; ra2 = 0;
        drive_wr(0, 32'hFFFFFFFF);
        #1;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            errors++; $display("FAIL r0_exe: rd1=%h rd2=%h required 0/0", rd1, rd2);
        end
        checks++;
        tick();
        wen_e = 0; #1;
        if (wb_valid !== 1'b0 || rd1 !== 32'h0 || rd2 !== 32'h0) begin
            errors++;
            $display("FAIL r0_wb: wb_valid=%b rd1=%h rd2=%h required 0/0/0", wb_valid, rd1, rd2);
        end
        checks++;
        tick(); tick();
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            errors++; $display("FAIL r0_array: rd1=%h rd2=%h required 0/0", rd1, rd2);
        end
        checks++;
    endtask

    task automatic test_forward_priority();
        idle(); ra1 = 7; ra2 = 7;
        drive_wr(7, 32'h11); #1;
        if (rd2 !== 32'h11) begin
            errors++; $display("FAIL fwd_n: rd2=%h required 11", rd2);
        end
        checks++;
        tick();
        drive_wr(7, 32'h22); #1;
        if (rd2 !== 32'h22 || rd1 !== rd2) begin
            errors++; $display("FAIL fwd_n1: rd2=%h rd1=%h required 22/22", rd2, rd1);
        end
        checks++;
        tick();
        wen_e = 0; #1;
        if (rd2 !== 32'h22) begin
            errors++; $display("FAIL fwd_n2: rd2=%h required 22", rd2);
        end
        checks++;
        tick();
        if (rd2 !== 32'h22 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL fwd_array: rd2=%h wb_valid=%b required 22/0", rd2, wb_valid);
        end
        checks++;
    endtask

    task automatic test_stall_flush();
        idle(); ra1 = 11; ra2 = 10;
        drive_wr(9, 32'h55); overflow = 0; negative = 1; carry = 0; tick();
        stall = 1; drive_wr(10, 32'hAA); overflow = 1; negative = 0; carry = 1;
        #1;
        if (rd2 !== 32'hAA) begin
            errors++; $display("FAIL stall_exe_fwd: rd2=%h required aa", rd2);
        end
        checks++;
        tick();
        if (wb_wd !== 32'h55 || wb_wa !== 5'd9 || wb_valid !== 1'b1 || flags !== 3'b010) begin
            errors++;
            $display("FAIL stall_hold: wb_wd=%h wb_wa=%0d wb_valid=%b flags=%b required 55/9/1/010",
                     wb_wd, wb_wa, wb_valid, flags);
        end
        checks++;
        stall = 0; drive_wr(11, 32'h77); overflow = 0; negative = 0; carry = 0; tick();
        stall = 1; flush = 1; drive_wr(12, 32'h99); tick();
        idle(); #1;
        if (wb_valid !== 1'b0 || wb_wd !== 32'h0 || wb_wa !== 5'd0 || rd1 !== 32'h77) begin
            errors++;
            $display("FAIL stall_flush: wb_valid=%b wb_wa=%0d wb_wd=%h rd1=%h required 0/0/0/77",
                     wb_valid, wb_wa, wb_wd, rd1);
        end
        checks++;
        if (flags !== 3'b000) begin
            errors++; $display("FAIL flush_flags: flags=%b required 000", flags);
        end
        checks++;
        tick();
    endtask

    task automatic test_flags();
        idle();
        drive_wr(13, 32'h1); overflow = 1; negative = 0; carry = 1; tick();
        if (flags !== 3'b101) begin
            errors++; $display("FAIL flags_load: flags=%b required 101", flags);
        end
        checks++;
        wen_e = 0; wa_e = 14; overflow = 0; negative = 1; carry = 0; tick();
        if (flags !== 3'b101) begin
            errors++; $display("FAIL flags_hold: flags=%b required 101", flags);
        end
        checks++;
        idle(); tick();
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 600; n++) begin
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            wen_e    = ($urandom_range(0, 3) != 0);
            wa_e     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) wa_e = 31;
            wd       = $urandom;
            {overflow, negative, carry} = 3'($urandom_range(0, 7));
            ra1      = 5'($urandom_range(0, 5));
            ra2      = ($urandom_range(0, 1) == 0) ? ra1 : 5'($urandom_range(0, 31));
            #1;
            e1 = model_read(ra1);
            e2 = model_read(ra2);
            if (rd1 !== e1 || rd2 !== e2) begin
                errors++;
                $display("FAIL rand_read[%0d]: ra1=%0d rd1=%h ra2=%0d rd2=%h required %h/%h",
                         n, ra1, rd1, ra2, rd2, e1, e2);
            end
            checks++;
            tick();
            if (wb_valid !== m_wb_valid || wb_wa !== m_wb_wa || wb_wd !== m_wb_wd || flags !== m_flags) begin
                errors++;
                $display("FAIL rand_wb[%0d]: %b/%0d/%h/%b required %b/%0d/%h/%b", n,
                         wb_valid, wb_wa, wb_wd, flags, m_wb_valid, m_wb_wa, m_wb_wd, m_flags);
            end
            checks++;
        end
        idle(); tick(); tick();
        for (int r = 0; r < 32; r++) begin
            ra1 = 5'(r); ra2 = 5'(31 - r); #1;
            if (rd1 !== m_regs[r] || rd2 !== m_regs[31 - r]) begin
                errors++;
                $display("FAIL rand_sweep[%0d]: rd1=%h rd2=%h required %h/%h",
                         r, rd1, rd2, m_regs[r], m_regs[31 - r]);
            end
            checks++;
        end
    endtask

    initial begin
        idle(); ra1 = 0; ra2 = 0;
        test_reset();
        test_write_path();
        test_r0();
        test_forward_priority();
        test_stall_flush();
        test_flags();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
